if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage with a prefetch queue, for the 5-stage MIPS pipeline, placed ahead of the IF/ID pipeline register. It issues word fetches to an instruction memory with variable response latency and buffers up to DEPTH {PC, instruction} pairs. It presents the head entry to decode, holds it under `freeze`, and flushes and redirects on a taken branch. Responses that were in flight when a branch redirected the stage are discarded.

## Interface
Parameters:
- WORD_SIZE, 32, width of PC, instruction and offsets
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset
- BR_SHIFT, 2, left shift applied to `brOffset`

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- brTaken  in  1  taken branch; redirect and flush
- brBase  in  WORD_SIZE  base address for branch target
- brOffset  in  WORD_SIZE  signed word offset
- freeze  in  1  decode stall; holds the head entry
- valid  out  1  head entry present
- PC  out  WORD_SIZE  PC+4 of head instruction (MIPS convention)
- instruction  out  WORD_SIZE  head instruction
- imem_req  out  1  fetch request, one-cycle strobe
- imem_addr  out  WORD_SIZE  fetch address, valid with `imem_req`
- imem_rvalid  in  1  response strobe
- imem_rdata  in  WORD_SIZE  response data

## Operation
- State: `fetchPC`, queue (count, rd/wr pointers), `outstanding`, `stale`.
- Branch target = brBase + (brOffset << BR_SHIFT), modulo 2^WORD_SIZE. Carries beyond WORD_SIZE are dropped.
- Request condition: `imem_req` = !brTaken && (!outstanding || imem_rvalid) && (count + outstanding) < DEPTH.
  - `count` and `outstanding` are the registered values.
  - Only one request may be in flight.
- `imem_addr` = `fetchPC`, driven combinationally.
- On a request, `fetchPC` advances by WORD_SIZE/8 and `outstanding` is set.
- Response handling on `imem_rvalid`:
  - `outstanding` clears, unless a new request is issued in the same cycle.
  - If `stale` is 0, push {request address + WORD_SIZE/8, imem_rdata}.
  - If `stale` is 1, drop the data and clear `stale`.
- Pop: when valid && !freeze, the head retires at the clock edge.
- `imem_rvalid` while `outstanding` = 0 is ignored.
- Branch (brTaken = 1) has priority over everything else:
  - queue count goes to 0;
  - `fetchPC` takes the branch target;
  - no request issues that cycle;
  - if a request is outstanding and not returning that cycle, set `stale`;
  - any push or pop in that cycle is discarded;
  - `freeze` is irrelevant.
- Simultaneous push and pop: the count is unchanged.
- Full queue: the request condition blocks fetch, so push-on-full cannot occur.
- Reset, asynchronous, effective immediately:
  - `fetchPC` = RESET_PC; count = 0; pointers = 0; `outstanding` = 0; `stale` = 0; storage cleared.
  - Outputs: valid = 0, PC = 0, instruction = 0, imem_req = 0, imem_addr = RESET_PC.
- Reset mid-request: the in-flight response is lost. The memory is reset by the same `rst`.

## Timing
- `imem_req` may assert in the first cycle after `rst` deasserts.
- Response latency L ≥ 1 cycle after the request.
- The pushed entry is visible on `valid`/`PC`/`instruction` in the cycle after `imem_rvalid`, so fetch-to-output latency is L+1.
- With L = 1 and no freeze: one instruction per cycle in steady state.
- Outputs are a registered queue head: no combinational path from `imem_rdata` or `freeze` to `PC`/`instruction`.
- `imem_req` is combinational from `brTaken` and `imem_rvalid`.
- After a branch in cycle n:
  - with nothing outstanding, the target request issues in cycle n+1;
  - with a stale request pending, the target request issues in the cycle its `imem_rvalid` arrives.

## Structure
- Shared package `if_pkg`:
  - WORD_SIZE default;
  - INSTR_BYTES (WORD_SIZE/8);
  - `fetch_entry_t` struct {pc, instr}.
- Sub-module `if_queue`:
  - DEPTH × `fetch_entry_t` circular buffer;
  - push, pop, flush, count;
  - registered head outputs;
  - pointer wrap modulo DEPTH.
- The top level holds `fetchPC`, the `outstanding`/`stale` flags, target arithmetic and the request logic.

## Test plan
- Reset, L = 1, no freeze:
  - imem_addr sequence 0, 4, 8, 12;
  - valid first rises 2 cycles after the first request;
  - PC outputs 4, 8, 12, 16 on consecutive cycles.
- Hold `freeze` = 1 for 10 cycles with DEPTH = 4:
  - exactly 4 entries are buffered, and `imem_req` stays low while full;
  - head holds PC = 4;
  - release drains 4, 8, 12, 16 back-to-back.
- Branch with brBase = 0x100, brOffset = −2 while a request is outstanding (L = 3):
  - the old response is dropped;
  - the next request is to 0xF8 and issues in the old response's cycle;
  - the queue is empty the cycle after the branch.
- Branch coincident with `imem_rvalid` and a pop:
  - count = 0 afterwards;
  - the next request is to the target in the following cycle.
- Target wrap: brBase = 0xFFFFFFFC, brOffset = 2 gives a fetch at 0x00000004.
- Assert `rst` low while the queue holds 3 entries and a request is outstanding:
  - outputs go to reset values immediately;
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch stage.
package if_pkg;
  localparam int WORD_SIZE   = 32;
  localparam int INSTR_BYTES = WORD_SIZE / 8;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_queue.sv
// Circular prefetch buffer of {PC, instruction} pairs; the head is read straight from storage registers.
module if_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               pushData,
  output logic                       valid,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] rdPtr, wrPtr;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rdPtr];
endmodule

// File: rtl/if_prefetch_stage.sv
// MIPS fetch stage: single-outstanding imem requests feeding a prefetch queue, with branch flush/redirect.
module if_prefetch_stage #(
  parameter int                          WORD_SIZE = if_pkg::WORD_SIZE,
  parameter int                          DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0]        RESET_PC  = '0,
  parameter int                          BR_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 brTaken,
  input  logic [WORD_SIZE-1:0] brBase,
  input  logic [WORD_SIZE-1:0] brOffset,
  input  logic                 freeze,
  output logic                 valid,
  output logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata
);
  import if_pkg::*;

  localparam int                   CW      = $clog2(DEPTH) + 1;
  localparam logic [WORD_SIZE-1:0] STEP    = WORD_SIZE'(INSTR_BYTES);
  localparam logic [CW:0]          DEPTH_W = (CW + 1)'(DEPTH);

  logic [WORD_SIZE-1:0] fetchPC, brTarget;
  logic                 outstanding, stale, rsp, push, pop, qValid;
  logic [CW-1:0]        count;
  fetch_entry_t         head, pushData;

  assign brTarget  = brBase + (brOffset << BR_SHIFT);
  assign rsp       = imem_rvalid && outstanding;
  assign imem_addr = fetchPC;
  assign imem_req  = rst && !brTaken && (!outstanding || imem_rvalid) &&
                     (({1'b0, count} + (CW + 1)'(outstanding)) < DEPTH_W);

  // A non-stale response always belongs to the last request, whose address + step is fetchPC.
  assign push     = rsp && !stale && !brTaken;
  assign pop      = qValid && !freeze && !brTaken;
  assign pushData = '{pc: fetchPC, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPC     <= RESET_PC;
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end else if (brTaken) begin
      // A request still in flight stays outstanding but its data will be dropped.
      fetchPC     <= brTarget;
      outstanding <= outstanding && !imem_rvalid;
      stale       <= outstanding && !imem_rvalid;
    end else begin
      if (imem_req) begin
        fetchPC     <= fetchPC + STEP;
        outstanding <= 1'b1;
      end else if (rsp) begin
        outstanding <= 1'b0;
      end
      if (rsp) stale <= 1'b0;
    end
  end

  if_queue #(.DEPTH(DEPTH)) uQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (brTaken),
    .pushData (pushData),
    .valid    (qValid),
    .head     (head),
    .count    (count)
  );

  assign valid       = qValid;
  assign PC          = head.pc;
  assign instruction = head.instr;
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: queue-based reference model, variable-latency memory, directed + random stimulus.
module tb_if_prefetch_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, brTaken, freeze, imem_rvalid, valid, imem_req;
  logic [31:0] brBase, brOffset, PC, instruction, imem_addr, imem_rdata;

  always #5 clk = ~clk;

  if_prefetch_stage #(.WORD_SIZE(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .BR_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .brTaken(brTaken), .brBase(brBase), .brOffset(brOffset),
    .freeze(freeze), .valid(valid), .PC(PC), .instruction(instruction),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  int          nAssert = 0, nFail = 0;
  ent_t        q[$];
  logic [31:0] mFetch, mReqAddr;
  bit          mOut, mStale;
  bit          memPend;
  int          memCnt;
  int          lat = 1;
  bit          randLat = 0, spurious = 0;
  logic        sValid, sReq;
  logic [31:0] sAddr, sPC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mFetch = RESET_PC; mReqAddr = '0; mOut = 0; mStale = 0;
    memPend = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  // One cycle: check at negedge, advance model, then drive memory response after posedge.
  task automatic tick();
    bit   expReq, rsp, doPop;
    ent_t e;
    @(negedge clk);
    sValid = valid; sReq = imem_req; sAddr = imem_addr; sPC = PC;
    if (!rst) begin
      chkb("reset valid", valid, 1'b0);
      chkb("reset imem_req", imem_req, 1'b0);
      chk("reset imem_addr", imem_addr, RESET_PC);
      chk("reset PC", PC, 32'h0);
      chk("reset instruction", instruction, 32'h0);
      modelReset();
    end else begin
      rsp    = imem_rvalid && mOut;
      expReq = !brTaken && (!mOut || imem_rvalid) && (q.size() + int'(mOut) < DEPTH);
      chkb("valid", valid, q.size() != 0);
      chkb("imem_req", imem_req, expReq);
      chk("imem_addr", imem_addr, mFetch);
      if (q.size() != 0) begin
        chk("PC", PC, q[0].pc);
        chk("instruction", instruction, q[0].ins);
      end
      if (brTaken) begin
        q.delete();
        mFetch = brBase + brOffset * 32'd4;
        mStale = mOut && !rsp;
        mOut   = mStale;
      end else begin
        doPop = (q.size() != 0) && !freeze;
        if (doPop) void'(q.pop_front());
        if (rsp) begin
          if (mStale) mStale = 0;
          else begin
            e.pc = mReqAddr + 32'd4; e.ins = imem_rdata;
            q.push_back(e);
          end
        end
        if (expReq) begin
          mReqAddr = mFetch; mFetch = mFetch + 32'd4; mOut = 1;
        end else if (rsp) mOut = 0;
      end
      if (expReq) begin
        memPend = 1;
        memCnt  = randLat ? int'($urandom_range(1, 4)) : lat;
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid = 0;
    if (memPend) begin
      memCnt--;
      if (memCnt == 0) begin
        memPend = 0; imem_rvalid = 1; imem_rdata = $urandom;
      end
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      imem_rvalid = 1; imem_rdata = $urandom;
    end
  endtask

  task automatic doReset(input int cyc);
    rst = 0; brTaken = 0; freeze = 0; memPend = 0; imem_rvalid = 0;
    #1;
    chkb("async reset valid", valid, 1'b0);
    chkb("async reset imem_req", imem_req, 1'b0);
    chk("async reset imem_addr", imem_addr, RESET_PC);
    chk("async reset PC", PC, 32'h0);
    chk("async reset instruction", instruction, 32'h0);
    repeat (cyc) tick();
    rst = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rA[6], rP[6];
    logic        rV[6];
    int          nReq;
    bit          reached;

    rst = 0; brTaken = 0; freeze = 0; brBase = '0; brOffset = '0;
    modelReset();
    doReset(2);

    // Streaming with L = 1.
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); rA[i] = sAddr; rV[i] = sValid; rP[i] = sPC;
    end
    for (int i = 0; i < 4; i++) chk("stream addr", rA[i], 32'(i * 4));
    chkb("valid before rise", rV[1], 1'b0);
    chkb("valid rise", rV[2], 1'b1);
    for (int i = 2; i < 6; i++) chk("stream PC", rP[i], 32'((i - 1) * 4));

    // Freeze fills the queue, then drains back-to-back.
    doReset(2);
    freeze = 1; nReq = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); nReq += int'(sReq);
    end
    chk("requests while frozen", 32'(nReq), 32'd4);
    chkb("req low when full", sReq, 1'b0);
    chk("head held", sPC, 32'h4);
    chk("model occupancy", 32'(q.size()), 32'd4);
    freeze = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); rP[i] = sPC; rV[i] = sValid;
    end
    for (int i = 0; i < 4; i++) begin
      chkb("drain valid", rV[i], 1'b1);
      chk("drain PC", rP[i], 32'((i + 1) * 4));
    end

    // Branch with a request outstanding, L = 3.
    doReset(2);
    lat = 3;
    tick(); chkb("first req", sReq, 1'b1);
    brTaken = 1; brBase = 32'h100; brOffset = 32'hFFFF_FFFE;
    tick(); brTaken = 0;
    tick(); chkb("empty after branch", sValid, 1'b0); chkb("held while stale", sReq, 1'b0);
    tick(); chkb("target req", sReq, 1'b1); chk("target addr", sAddr, 32'hF8);
    tick(); chkb("stale dropped", sValid, 1'b0);
    tick(); tick();
    tick(); chkb("target valid", sValid, 1'b1); chk("target PC", sPC, 32'hFC);

    // Branch coincident with response and pop.
    doReset(2);
    lat = 1;
    repeat (5) tick();
    brTaken = 1; brBase = 32'h2000; brOffset = 32'h1;
    tick(); brTaken = 0;
    chkb("popping at branch", sValid, 1'b1);
    tick(); chkb("flushed", sValid, 1'b0); chkb("redirect req", sReq, 1'b1);
    chk("redirect addr", sAddr, 32'h2004);

    // Target arithmetic wraps.
    brTaken = 1; brBase = 32'hFFFF_FFFC; brOffset = 32'h2;
    tick(); brTaken = 0;
    tick(); chk("wrap addr", sAddr, 32'h4); chkb("wrap req", sReq, 1'b1);

    // Reset with three entries buffered and a request in flight.
    doReset(2);
    lat = 3; freeze = 1; reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick(); reached = (q.size() == 3) && mOut;
    end
    chkb("prefill reached", reached, 1'b1);
    chkb("prefill valid", sValid, 1'b1);
    doReset(2);
    lat = 1;
    tick(); chkb("restart req", sReq, 1'b1); chk("restart addr", sAddr, RESET_PC);

    // Randomised traffic.
    randLat = 1; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      brTaken  = ($urandom_range(0, 11) == 0);
      brBase   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255) * 4);
      brOffset = 32'($urandom_range(0, 64)) - 32'd32;
      freeze   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) doReset(1 + int'($urandom_range(0, 1)));
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
